uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Asynchronous serial receiver for the board UART link. It is the receive end of the in-house 8-N-1 transmitter.
- Line format:
  - idle high
  - one start bit (0)
  - 8 data bits, LSB first, transmitted inverted relative to the byte value
  - one stop bit (1)
- The block recovers bit timing by 16x oversampling from sysclk, reassembles the byte, and presents it to the CPU peripheral bus logic with a one-cycle valid strobe. It also reports a framing error.

Parameters:
- CLK_FREQ, 100_000_000, sysclk frequency in Hz.
- BAUD, 9600, line bit rate in bit/s.
- OVERSAMPLE, 16, ticks per bit period; fixed at 16, the value behaviour below is written for.
- DATA_INV, 1:
  - 1 = line data bits are the complement of the byte, so the receiver inverts them.
  - 0 = plain UART.
- Derived (localparam): DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer truncation; DIV >= 2 required.

Ports:
- sysclk     input   1  system clock; all logic on rising edge.
- reset      input   1  asynchronous, active-high reset.
- enable     input   1  receiver enable; low forces IDLE.
- UART_RX    input   1  serial line from pin, asynchronous to sysclk.
- RX_DATA    output  8  last correctly framed byte; held until the next good frame.
- RX_STATUS  output  1  one-sysclk pulse when RX_DATA is updated.
- busy       output  1  high while a frame is in progress (state != IDLE).
- frame_err  output  1  level; result of the most recent stop-bit check.

Behaviour:
- Reset (async, active-high):
  - state=IDLE.
  - Both synchronizer flops = 1.
  - Tick counter, sample counter, bit index and shift register = 0.
  - RX_DATA=8'h00, RX_STATUS=0, busy=0, frame_err=0.
- Input sync:
  - UART_RX passes through two flops (rx_s).
  - A third flop (rx_d) holds the previous rx_s value for edge detection.
- Tick generator:
  - Counter runs 0..DIV-1; tick is high for one sysclk when the count equals DIV-1.
  - The counter is cleared on start detection, so ticks are phase-aligned to the frame.
  - Held at 0 in IDLE.
- States IDLE, START, DATA, STOP; s_cnt is a 4-bit tick counter and bit_idx is 3-bit.
  - IDLE: when enable=1, rx_d=1 and rx_s=0 (falling edge):
    - go to START.
    - s_cnt=0, tick counter=0.
    - A level-low line without a preceding high never starts a frame.
  - START: each tick s_cnt++. On the tick where s_cnt==7 (mid start bit):
    - rx_s==0: go to DATA, s_cnt=0, bit_idx=0.
    - rx_s==1: glitch; return to IDLE with no output.
  - DATA: each tick s_cnt++. On the tick where s_cnt==15 (mid data bit):
    - shift rx_s into the MSB of the shift register (right shift, so LSB-first).
    - s_cnt=0 and bit_idx++.
    - After bit_idx==7 is sampled, go to STOP.
  - STOP: on the tick where s_cnt==15 (mid stop bit), return to IDLE and:
    - rx_s==1:
      - RX_DATA <= DATA_INV ? ~shift : shift.
      - RX_STATUS=1 for exactly the next sysclk.
      - frame_err=0.
    - rx_s==0:
      - frame_err=1; RX_DATA unchanged; no RX_STATUS.
- Next frame: returning to IDLE at mid stop bit allows a back-to-back start bit to be caught. A following frame's start edge is accepted as soon as the line has been seen high in IDLE.
- enable deasserted: any state goes to IDLE on the next sysclk. The partial frame is discarded; RX_DATA and frame_err are held.
- Timing:
  - RX_STATUS rises 9.5 bit periods (152*DIV sysclk) plus 3–4 sysclk of sync/register latency after the pin's start edge.
  - Sampling point error is at most 1 tick (1/16 bit).
- Overrun: none tracked. A new good frame overwrites RX_DATA and re-pulses RX_STATUS; the consumer must capture it on the pulse.
- Simultaneous events:
  - reset dominates everything.
  - enable=0 dominates a stop-bit completion on the same cycle: no pulse, no update.

Decomposition:
- Shared package (uart_pkg):
  - state encoding constants for IDLE/START/DATA/STOP (2 bits).
  - OVERSAMPLE=16, MID_START=7, LAST_TICK=15.
  - 8-N-1 frame constants (DATA_BITS=8).
  - The same constants are reused by the transmitter.
- One sub-module, uart_rx_tick:
  - the DIV counter with synchronous clear and run inputs.
  - outputs the tick strobe.
- Synchronizer and FSM stay in uart_receiver.

Test Plan (sim params CLK_FREQ=1_600_000, BAUD=10_000, so DIV=10 and bit=160 sysclk):
- Single frame, DATA_INV=1, byte 8'hA5 (line bits ~A5 = 8'h5A LSB-first, stop=1) -> one RX_STATUS pulse ~1520 sysclk after the start edge; RX_DATA=8'hA5; frame_err=0; busy high for the frame duration.
- DATA_INV=0, back-to-back bytes 8'h00 then 8'hFF with no idle gap -> two RX_STATUS pulses 1600 sysclk apart; RX_DATA 8'h00 then 8'hFF.
- Line low for 40 sysclk (< half bit), then high -> START aborts at mid-bit check; no RX_STATUS; busy returns to 0; RX_DATA unchanged.
- Frame 8'h3C with stop bit driven 0 -> frame_err=1, no RX_STATUS, RX_DATA keeps its previous value. Line held low afterwards does not start a frame until it returns high. A following good frame 8'h3C gives RX_STATUS and frame_err=0.
- enable dropped at bit 4 of a frame and raised 200 sysclk later -> immediate IDLE, no output. The next complete frame 8'h81 is received correctly.
- reset asserted mid-DATA (async, between clock edges) -> all outputs 0 immediately; the next frame 8'h55 after release is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared 8-N-1 UART definitions: FSM state encoding and frame/oversampling
// constants used by both the receiver and the transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] MID_START  = 4'd7;
  localparam logic [3:0] LAST_TICK  = 4'd15;
  localparam int         DATA_BITS  = 8;

endpackage

// File: rtl/uart_rx_tick.sv
// Oversampling tick generator: one-cycle strobe every DIV sysclk cycles while
// running, phase-restartable by a synchronous clear.
module uart_rx_tick #(
  parameter int DIV = 10
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int             W    = $clog2(DIV);
  localparam logic [W-1:0]   LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset)                cnt <= '0;
    else if (clear || !run)   cnt <= '0;
    else if (cnt == LAST)     cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

  assign tick = run && (cnt == LAST);

endmodule

// File: rtl/uart_receiver.sv
// 8-N-1 serial receiver with 16x oversampling, optional line-data inversion,
// one-cycle receive strobe and framing-error flag.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_INV   = 1
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       enable,
  input  logic       UART_RX,
  output logic [7:0] RX_DATA,
  output logic       RX_STATUS,
  output logic       busy,
  output logic       frame_err
);

  localparam int         DIV      = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic rx_meta, rx_s, rx_d;
  logic tick, tick_clear;

  uart_state_e state_q, state_n;
  logic [3:0]  s_cnt_q, s_cnt_n;
  logic [2:0]  bit_idx_q, bit_idx_n;
  logic [7:0]  shift_q, shift_n;
  logic [7:0]  rx_data_q, rx_data_n;
  logic        rx_status_q, rx_status_n;
  logic        frame_err_q, frame_err_n;

  // Idle-high reset values keep a spurious falling edge from appearing on release.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, which is what makes this a true 3-stage chain.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_d    <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_s    <= rx_meta;
      rx_d    <= rx_s;
    end
  end

  uart_rx_tick #(.DIV(DIV)) u_tick (
    .sysclk (sysclk),
    .reset  (reset),
    .clear  (tick_clear),
    .run    (state_q != IDLE),
    .tick   (tick)
  );

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      s_cnt_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_status_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      s_cnt_q     <= s_cnt_n;
      bit_idx_q   <= bit_idx_n;
      shift_q     <= shift_n;
      rx_data_q   <= rx_data_n;
      rx_status_q <= rx_status_n;
      frame_err_q <= frame_err_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_n     = state_q;
    s_cnt_n     = s_cnt_q;
    bit_idx_n   = bit_idx_q;
    shift_n     = shift_q;
    rx_data_n   = rx_data_q;
    rx_status_n = 1'b0;
    frame_err_n = frame_err_q;
    tick_clear  = 1'b0;

    if (!enable) begin
      state_n = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (rx_d && !rx_s) begin
            state_n    = START;
            s_cnt_n    = '0;
            tick_clear = 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (s_cnt_q == MID_START) begin
              s_cnt_n   = '0;
              bit_idx_n = '0;
              state_n   = rx_s ? IDLE : DATA;
            end else begin
              s_cnt_n = s_cnt_q + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s_cnt_q == LAST_TICK) begin
              shift_n   = {rx_s, shift_q[7:1]};
              s_cnt_n   = '0;
              bit_idx_n = bit_idx_q + 3'd1;
              if (bit_idx_q == LAST_BIT) state_n = STOP;
            end else begin
              s_cnt_n = s_cnt_q + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (s_cnt_q == LAST_TICK) begin
              // Leaving at mid stop bit leaves half a bit to catch a back-to-back start.
              state_n = IDLE;
              s_cnt_n = '0;
              if (rx_s) begin
                rx_data_n   = (DATA_INV != 0) ? ~shift_q : shift_q;
                rx_status_n = 1'b1;
                frame_err_n = 1'b0;
              end else begin
                frame_err_n = 1'b1;
              end
            end else begin
              s_cnt_n = s_cnt_q + 4'd1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign RX_DATA   = rx_data_q;
  assign RX_STATUS = rx_status_q;
  assign busy      = (state_q != IDLE);
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized + directed bench for uart_receiver: one inverting and one plain
// instance share the line; a queue-based scoreboard checks every receive strobe.
module tb_uart_receiver;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 10_000;
  localparam int BIT_CYC  = CLK_FREQ / BAUD;          // 160 sysclk per bit
  localparam int PULSE_AT = 3 + (19 * BIT_CYC) / 2;   // 9.5 bits + sync latency

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b1;
  logic       enable = 1'b0;
  logic       UART_RX = 1'b1;
  logic [7:0] data_inv, data_plain;
  logic       st_inv, st_plain, busy_inv, busy_plain, ferr_inv, ferr_plain;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  exp_t       q_inv[$];
  exp_t       q_plain[$];
  logic [7:0] last_inv   = 8'h00;
  logic [7:0] last_plain = 8'h00;
  logic       exp_ferr   = 1'b0;

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  uart_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16), .DATA_INV(1)) u_inv (
    .sysclk(sysclk), .reset(reset), .enable(enable), .UART_RX(UART_RX),
    .RX_DATA(data_inv), .RX_STATUS(st_inv), .busy(busy_inv), .frame_err(ferr_inv)
  );

  uart_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16), .DATA_INV(0)) u_plain (
    .sysclk(sysclk), .reset(reset), .enable(enable), .UART_RX(UART_RX),
    .RX_DATA(data_plain), .RX_STATUS(st_plain), .busy(busy_plain), .frame_err(ferr_plain)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic check_idle_state(input string tag);
    check({tag, "_busy_inv"},   busy_inv,   1'b0);
    check({tag, "_busy_plain"}, busy_plain, 1'b0);
    check({tag, "_data_inv"},   data_inv,   last_inv);
    check({tag, "_data_plain"}, data_plain, last_plain);
    check({tag, "_ferr_inv"},   ferr_inv,   exp_ferr);
    check({tag, "_ferr_plain"}, ferr_plain, exp_ferr);
  endtask

  // Sends one complete frame of raw line bits; a good stop bit yields one
  // expected byte per instance, due 9.5 bit periods after the start edge.
  task automatic send_frame(input logic [7:0] line, input logic stop_bit);
    int c0;
    c0 = cyc;
    if (stop_bit) begin
      q_inv.push_back('{data: ~line, cyc: c0 + PULSE_AT});
      q_plain.push_back('{data: line, cyc: c0 + PULSE_AT});
      last_inv   = ~line;
      last_plain = line;
      exp_ferr   = 1'b0;
    end else begin
      exp_ferr = 1'b1;
    end
    UART_RX = 1'b0;
    cycles(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      UART_RX = line[i];
      cycles(BIT_CYC / 2);
      if (i == 3) begin
        check("busy_mid_frame_inv",   busy_inv,   1'b1);
        check("busy_mid_frame_plain", busy_plain, 1'b1);
      end
      cycles(BIT_CYC - BIT_CYC / 2);
    end
    UART_RX = stop_bit;
    cycles(BIT_CYC);
  endtask

  // Scoreboard monitor: every strobe must match the oldest outstanding expectation.
  initial forever begin
    exp_t e;
    @(negedge sysclk);
    if (!reset && st_inv) begin
      check("inv_pulse_expected", q_inv.size() > 0, 1'b1);
      if (q_inv.size() > 0) begin
        e = q_inv.pop_front();
        check("inv_rx_data", data_inv, e.data);
        check_range("inv_pulse_cycle", cyc, e.cyc - 1, e.cyc + 2);
        check("inv_ferr_on_pulse", ferr_inv, 1'b0);
      end
    end
    if (!reset && st_plain) begin
      check("plain_pulse_expected", q_plain.size() > 0, 1'b1);
      if (q_plain.size() > 0) begin
        e = q_plain.pop_front();
        check("plain_rx_data", data_plain, e.data);
        check_range("plain_pulse_cycle", cyc, e.cyc - 1, e.cyc + 2);
        check("plain_ferr_on_pulse", ferr_plain, 1'b0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] line;
    logic       stop_bit;

    // Reset state
    cycles(5);
    check_idle_state("reset");
    check("reset_status_inv", st_inv, 1'b0);
    reset  = 1'b0;
    enable = 1'b1;
    cycles(20);

    // Inverting instance sees 8'hA5 when the line carries 8'h5A
    send_frame(8'h5A, 1'b1);
    cycles(10);
    check_idle_state("single");

    // Back-to-back frames, no idle gap: plain instance gets 00 then FF
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    cycles(10);
    check_idle_state("b2b");

    // 40-cycle glitch is rejected at the mid start-bit check
    UART_RX = 1'b0;
    cycles(40);
    UART_RX = 1'b1;
    cycles(300);
    check_idle_state("glitch");

    // Bad stop bit, then line held low: no frame until it returns high
    send_frame(8'hC3, 1'b0);
    cycles(400);
    check_idle_state("ferr_low");
    UART_RX = 1'b1;
    cycles(20);
    send_frame(8'hC3, 1'b1);
    cycles(10);
    check_idle_state("ferr_recover");

    // enable dropped in bit 4, raised 200 cycles later
    UART_RX = 1'b0;
    cycles(BIT_CYC * 5 + 40);
    check("en_busy_before_drop", busy_inv, 1'b1);
    enable = 1'b0;
    cycles(2);
    check_idle_state("en_drop");
    cycles(198);
    UART_RX = 1'b1;
    enable  = 1'b1;
    cycles(100);
    send_frame(8'h7E, 1'b1);
    cycles(10);
    check_idle_state("en_recover");

    // Asynchronous reset mid-DATA, between clock edges
    UART_RX = 1'b0;
    cycles(BIT_CYC * 3 + 20);
    #2 reset = 1'b1;
    #1;
    last_inv   = 8'h00;
    last_plain = 8'h00;
    exp_ferr   = 1'b0;
    check_idle_state("async_reset");
    check("async_reset_status", st_inv, 1'b0);
    cycles(4);
    UART_RX = 1'b1;
    reset   = 1'b0;
    cycles(50);
    send_frame(8'hAA, 1'b1);
    cycles(10);
    check_idle_state("post_reset");

    // Randomized frames with occasional framing errors and random gaps
    for (int r = 0; r < 8; r++) begin
      line     = 8'($urandom_range(0, 255));
      stop_bit = ($urandom_range(0, 3) != 0);
      send_frame(line, stop_bit);
      UART_RX = 1'b1;
      cycles(5 + $urandom_range(0, 300));
      check_idle_state("random");
    end

    cycles(20);
    check("inv_all_received",   q_inv.size(),   0);
    check("plain_all_received", q_plain.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
